// File: rtl/ray_pkg.sv
// Shared ray tracer types and default sizes used by the front-end queue,
// ray_tracer_top and the intersection stage.
package ray_pkg;

    localparam int D_BITS     = 32;  // bits per ray word
    localparam int Q_BITS     = 16;  // fractional bits of the fixed-point words
    localparam int N_WORDS    = 6;   // origin xyz + direction xyz
    localparam int ID_BITS    = 8;
    localparam int DEPTH_LOG2 = 4;
    localparam int AF_THRESH  = 12;

    typedef logic signed [D_BITS-1:0] word_t;
    typedef word_t [N_WORDS-1:0]      ray_t;
    typedef logic [ID_BITS-1:0]       ray_id_t;

    // Accepted operations in one cycle, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } q_op_e;

endpackage

// File: rtl/ray_queue_ctrl.sv
// Queue bookkeeping: pointers, occupancy, flags, sticky errors and the
// sequential ray ID counter. The storage array lives in ray_queue.
module ray_queue_ctrl
    import ray_pkg::*;
#(
    parameter int DEPTH_LOG2 = ray_pkg::DEPTH_LOG2,
    parameter int ID_BITS    = ray_pkg::ID_BITS,
    parameter int AF_THRESH  = ray_pkg::AF_THRESH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    output logic                  wr_accept_o,
    output logic [DEPTH_LOG2-1:0] wr_ptr_o,
    output logic [DEPTH_LOG2-1:0] rd_ptr_o,
    output logic [ID_BITS-1:0]    next_id_o,
    output logic [DEPTH_LOG2:0]   count_o,
    output logic                  full_o,
    output logic                  almost_full_o,
    output logic                  empty_o,
    output logic                  err_overflow_o,
    output logic                  err_underflow_o
);

    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(1 << DEPTH_LOG2);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ID_BITS-1:0]    next_id_q, next_id_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, full_d, af_q, af_d, empty_q, empty_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  wr_acc, rd_acc;
    q_op_e                 op;

    // Next-state: acceptance, pointer/count/ID update, flush and error flags.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        next_id_d = next_id_q;
        count_d   = count_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;

        // Acceptance uses the registered flags, so a pop never frees room for a
        // push in the same cycle and a push never feeds a pop in the same cycle.
        wr_acc = wr_en_i & ~full_q  & ~flush_i;
        rd_acc = rd_en_i & ~empty_q & ~flush_i;
        op     = q_op_e'({wr_acc, rd_acc});

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            ovf_d = ovf_q | (wr_en_i & full_q);
            unf_d = unf_q | (rd_en_i & empty_q);
            case (op)
                OP_PUSH: count_d = count_q + 1'b1;
                OP_POP:  count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (wr_acc) begin
                wr_ptr_d  = wr_ptr_q + 1'b1;
                next_id_d = next_id_q + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end

        full_d  = (count_d == DEPTH_C);
        af_d    = (count_d >= AF_C);
        empty_d = (count_d == '0);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: non-blocking assignments model flops updating together on the edge.
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            next_id_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            af_q      <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            next_id_q <= next_id_d;
            count_q   <= count_d;
            full_q    <= full_d;
            af_q      <= af_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    assign wr_accept_o     = wr_acc;
    assign wr_ptr_o        = wr_ptr_q;
    assign rd_ptr_o        = rd_ptr_q;
    assign next_id_o       = next_id_q;
    assign count_o         = count_q;
    assign full_o          = full_q;
    assign almost_full_o   = af_q;
    assign empty_o         = empty_q;
    assign err_overflow_o  = ovf_q;
    assign err_underflow_o = unf_q;

endmodule

// File: rtl/ray_queue.sv
// First-word-fall-through ray queue: stores whole rays with a sequential ID
// and presents the head entry combinationally.
module ray_queue
    import ray_pkg::*;
#(
    parameter int D_BITS     = ray_pkg::D_BITS,
    parameter int N_WORDS    = ray_pkg::N_WORDS,
    parameter int DEPTH_LOG2 = ray_pkg::DEPTH_LOG2,
    parameter int ID_BITS    = ray_pkg::ID_BITS,
    parameter int AF_THRESH  = ray_pkg::AF_THRESH
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_wr_en,
    input  logic [N_WORDS-1:0][D_BITS-1:0] ray_in,
    output logic                           in_full,
    output logic                           in_almost_full,
    input  logic                           out_rd_en,
    output logic [N_WORDS-1:0][D_BITS-1:0] ray_out,
    output logic [ID_BITS-1:0]             ray_id,
    output logic                           out_empty,
    output logic [DEPTH_LOG2:0]            count,
    output logic                           err_overflow,
    output logic                           err_underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [N_WORDS-1:0][D_BITS-1:0] data_mem [DEPTH];
    logic [ID_BITS-1:0]             id_mem   [DEPTH];

    logic                  wr_accept;
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [ID_BITS-1:0]    next_id;

    ray_queue_ctrl #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .ID_BITS    (ID_BITS),
        .AF_THRESH  (AF_THRESH)
    ) u_ctrl (
        .clock           (clock),
        .reset           (reset),
        .flush_i         (flush),
        .wr_en_i         (in_wr_en),
        .rd_en_i         (out_rd_en),
        .wr_accept_o     (wr_accept),
        .wr_ptr_o        (wr_ptr),
        .rd_ptr_o        (rd_ptr),
        .next_id_o       (next_id),
        .count_o         (count),
        .full_o          (in_full),
        .almost_full_o   (in_almost_full),
        .empty_o         (out_empty),
        .err_overflow_o  (err_overflow),
        .err_underflow_o (err_underflow)
    );

    // Storage write: capture the ray and its ID at the write pointer.
    always_ff @(posedge clock) begin
        // NOTE: the data array has no reset; entries are only read once written, so it maps to plain RAM.
        if (wr_accept) begin
            data_mem[wr_ptr] <= ray_in;
            id_mem[wr_ptr]   <= next_id;
        end
    end

    assign ray_out = data_mem[rd_ptr];
    assign ray_id  = id_mem[rd_ptr];

endmodule

// File: doc/ray_queue.md
# ray_queue

Parametrised input queue for the ray tracer front end: it accepts whole rays as N_WORDS parallel words per write and tags each accepted ray with a sequential ray ID. It presents rays to the intersection pipeline in first-word-fall-through order. It generalises the fixed six-word ray input of ray_tracer_top with configurable width, depth and ray size, and adds occupancy and almost-full flags, flush, and sticky error flags.

## Interface
- D_BITS, 32, bits per ray word (signed fixed point, Q_BITS fractional; the queue does not interpret the value)
- N_WORDS, 6, words per ray (origin xyz + direction xyz)
- DEPTH_LOG2, 4, queue depth = 2^DEPTH_LOG2 rays
- ID_BITS, 8, ray ID width
- AF_THRESH, 12, in_almost_full asserts when count >= AF_THRESH

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of queue contents
- in_wr_en  in  1  write one ray
- ray_in  in  [N_WORDS] x D_BITS  ray words, sampled when in_wr_en=1
- in_full  out  1  count == 2^DEPTH_LOG2
- in_almost_full  out  1  count >= AF_THRESH
- out_rd_en  in  1  pop head ray
- ray_out  out  [N_WORDS] x D_BITS  head ray, valid while out_empty=0
- ray_id  out  ID_BITS  ID of head ray
- out_empty  out  1  count == 0
- count  out  DEPTH_LOG2+1  current occupancy
- err_overflow  out  1  sticky: write attempted while full
- err_underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: 2^DEPTH_LOG2 entries of {ID, N_WORDS words}; wr_ptr and rd_ptr are DEPTH_LOG2 bits and wrap modulo depth; count is held in its own register.
- Write accepted iff in_wr_en=1, in_full=0 and flush=0. The entry stores ray_in and next_id, wr_ptr advances, and next_id increments modulo 2^ID_BITS (255 -> 0 for ID_BITS=8).
- Write while full: data dropped, no state change, err_overflow set. A simultaneous out_rd_en does not make room in that cycle.
- Read accepted iff out_rd_en=1, out_empty=0 and flush=0; rd_ptr advances.
- Read while empty: ignored, err_underflow set. This applies even if a write is accepted in the same cycle.
- Simultaneous accepted read and write: count unchanged, both pointers advance.
- flush=1 takes priority over in_wr_en and out_rd_en. It zeroes pointers and count and clears both error flags. next_id is retained.
- Error flags are cleared only by reset or flush.
- Ray words are passed through bit-exact; there is no arithmetic on data.

## Timing
- Reset (reset=0, asynchronous): pointers, count and next_id = 0; out_empty=1; in_full=0; in_almost_full=0; err_overflow=0; err_underflow=0. ray_out and ray_id are don't-care while empty.
- All flags and count are registered and update on the edge that changes state.
- Write-to-read latency is 1 cycle: a ray written at edge k appears on ray_out/ray_id with out_empty=0 after edge k.
- FWFT: ray_out and ray_id show the head entry combinationally from rd_ptr. After a pop at edge k, the next entry is visible after edge k.
- Full throughput is one write and one read per cycle sustained.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge. Contents are lost and IDs restart at 0.
- Pointer wrap at entry 2^DEPTH_LOG2-1 -> 0 is seamless.

## Structure
- Shared package ray_pkg holds:
  - D_BITS, Q_BITS and N_WORDS defaults
  - typedef ray_t (array of N_WORDS signed D_BITS words)
  - typedef ray_id_t
- ray_tracer_top and the intersection stage import the same types from ray_pkg.
- One sub-module, ray_queue_ctrl, holds pointers, count, flags and next_id. The storage array stays in ray_queue.
- Storage is inferred memory with no reset on the data array.

## Test plan
- Reset then idle: out_empty=1, count=0, all other flags 0; no change over 10 cycles.
- Write 3 rays with words 1..6, 2..7 and 3..8, then pop 3 → IDs 0,1,2 in order with exact words; out_empty=1 afterwards.
- Fill to 16 (defaults): in_almost_full rises at count=12 and in_full at 16. A 17th write leaves count=16 and sets err_overflow; contents are intact.
- Full queue with simultaneous write and read: the write is dropped, count goes 16→15, and err_overflow=1. Then 20 cycles of simultaneous read and write on a half-full queue keep count constant, and pointers wrap correctly.
- Write 300 rays while draining concurrently: ray_id wraps 255→0; read while empty sets err_underflow; flush clears the flag and count while the next ID continues the sequence.
- Assert reset mid-stream with count=5: all outputs return to reset values without waiting for a clock edge, and the next accepted write gets ID 0.
